// File: rtl/fpga_bootrom_pkg.sv
// fpga_bootrom_pkg: shared response type, response kinds and constants for the bootrom bus adapter.
package fpga_bootrom_pkg;
  localparam int DATA_W = 32;
  localparam int RESP_DEPTH = 2;
  localparam logic [DATA_W-1:0] TRAP_INSN = 32'h0000_006F;
  typedef enum logic [1:0] {ROM, WERR, OOR} kind_t;
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;
endpackage

// File: rtl/bootrom_resp_fifo.sv
// bootrom_resp_fifo: 2-entry in-order fall-through response buffer; an empty buffer passes din straight to dout.
module bootrom_resp_fifo
  import fpga_bootrom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  resp_t      din,
  output logic       valid,
  output logic       full,
  output logic       empty,
  output resp_t      dout,
  output logic [1:0] occupancy
);
  resp_t mem [RESP_DEPTH];
  logic [1:0] cnt;
  logic wr_ptr, rd_ptr, wr, rd;
  assign empty = cnt == 2'd0;
  assign full = cnt == 2'(RESP_DEPTH);
  assign valid = !empty || push;
  assign dout = empty ? din : mem[rd_ptr];
  assign occupancy = cnt;
  // a fall-through entry consumed in its arrival cycle never touches storage
  assign wr = push && !(empty && pop);
  assign rd = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr <= !wr_ptr;
      end
      if (rd) rd_ptr <= !rd_ptr;
      cnt <= cnt + 2'(wr) - 2'(rd);
    end
  end
endmodule

// File: rtl/fpga_bootrom_bus_adapter.sv
// fpga_bootrom_bus_adapter: TCDM request port to bootrom CEN/A/Q bridge with decode, bounds check and 2-deep response buffer.
// Define FPGA_BOOTROM_TRAP_FILL_EN to answer out-of-range reads with a jal x0,0 trap instead of an error.
module fpga_bootrom_bus_adapter
  import fpga_bootrom_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = DATA_W,
  parameter int                    ROM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE       = 32'h1A00_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     add_i,
  input  logic                      wen_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [DATA_WIDTH-1:0]     r_rdata_o,
  output logic                      r_err_o,
  output logic                      rom_cen_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_a_o,
  input  logic [DATA_WIDTH-1:0]     rom_q_i
);
`ifdef FPGA_BOOTROM_TRAP_FILL_EN
  localparam resp_t OOR_RESP = resp_t'{rdata: TRAP_INSN, err: 1'b0};
`else
  localparam resp_t OOR_RESP = resp_t'{rdata: '0, err: 1'b1};
`endif
  logic [ADDR_WIDTH-1:0] off;
  logic [ROM_ADDR_WIDTH-1:0] index, a_q;
  logic [1:0] occ, used;
  logic in_range, inflight, pop, fifo_valid, full, empty, unused;
  kind_t kind;
  resp_t resp, head;
  assign off = add_i - ROM_BASE;
  assign in_range = add_i >= ROM_BASE && (off >> (ROM_ADDR_WIDTH + 2)) == '0 && add_i[1:0] == 2'b00;
  assign index = off[ROM_ADDR_WIDTH+1:2];
  // a pop this cycle frees its slot immediately, so grant can re-assert in the same cycle
  assign used = occ + {1'b0, inflight} - {1'b0, pop};
  assign gnt_o = req_i && !rst_i && used < 2'd2;
  assign rom_cen_o = !(gnt_o && wen_i && in_range);
  assign rom_a_o = (req_i && !rst_i) ? index : a_q;
  assign resp = (kind == ROM) ? resp_t'{rdata: rom_q_i, err: 1'b0} :
                (kind == WERR) ? resp_t'{rdata: '0, err: 1'b1} : OOR_RESP;
  assign r_valid_o = fifo_valid && !rst_i;
  assign pop = r_valid_o && r_ready_i;
  assign {r_rdata_o, r_err_o} = r_valid_o ? head : '0;
  assign unused = ^{be_i, wdata_i, full, empty};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      kind <= ROM;
      a_q <= '0;
    end else begin
      inflight <= gnt_o;
      a_q <= rom_a_o;
      if (gnt_o) kind <= !wen_i ? WERR : in_range ? ROM : OOR;
    end
  end
  bootrom_resp_fifo u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(inflight),
    .pop(pop),
    .din(resp),
    .valid(fifo_valid),
    .full(full),
    .empty(empty),
    .dout(head),
    .occupancy(occ)
  );
endmodule

// File: tb/tb_fpga_bootrom_bus_adapter.sv
// tb_fpga_bootrom_bus_adapter: directed vector table plus randomized traffic against a queue-based response model.
module tb_fpga_bootrom_bus_adapter;
  localparam logic [31:0] B = 32'h1A00_0000;
`ifdef FPGA_BOOTROM_TRAP_FILL_EN
  localparam logic [31:0] OD = 32'h0000_006F;
  localparam bit OE = 1'b0;
`else
  localparam logic [31:0] OD = 32'h0;
  localparam bit OE = 1'b1;
`endif
  typedef struct {
    bit rst, req;
    logic [31:0] add;
    bit wen, rdy, gnt, cen;
    logic [9:0] a;
    bit valid;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    bit e;
    int born;
  } ent_t;
  logic clk = 1'b0, rst, req, gnt, wen, rdy, r_valid, r_err, rom_cen;
  logic [31:0] add, wdata, r_rdata, rom_q;
  logic [3:0] be;
  logic [9:0] rom_a;
  int errors = 0, checks = 0, cyc = 0;
  ent_t q_m[$];
  logic [9:0] last_a = '0;
  bit s_gnt, s_cen, s_valid, s_err;
  logic [9:0] s_a;
  logic [31:0] s_rdata;
  vec_t tv[28];
  always #5 clk = ~clk;
  fpga_bootrom_bus_adapter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .be_i(be), .wdata_i(wdata), .r_valid_o(r_valid), .r_ready_i(rdy), .r_rdata_o(r_rdata),
    .r_err_o(r_err), .rom_cen_o(rom_cen), .rom_a_o(rom_a), .rom_q_i(rom_q)
  );
  function automatic logic [31:0] rom_word(input logic [9:0] i);
    return (i == 10'd0) ? 32'h1C008537 : ((32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
  endfunction
  // ROM macro: data appears the cycle after an enabled access, otherwise garbage
  always @(posedge clk) rom_q <= !rom_cen ? rom_word(rom_a) : $urandom;
  function automatic bit in_rng(input logic [31:0] ad);
    return {32'h0, ad} >= {32'h0, B} && {32'h0, ad} < {32'h0, B} + 64'd4096 && ad[1:0] == 2'b00;
  endfunction
  function automatic logic [9:0] idx(input logic [31:0] ad);
    logic [31:0] d;
    d = ad - B;
    return d[11:2];
  endfunction
  function automatic vec_t v(bit r, q, logic [31:0] ad, bit w, y, g, c, logic [9:0] a, bit vl, logic [31:0] d, bit e);
    return '{r, q, ad, w, y, g, c, a, vl, d, e};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic step(input bit r, q, input logic [31:0] ad, input bit w, y);
    bit e_valid, e_pop, e_gnt, e_cen;
    logic [9:0] e_a;
    ent_t n;
    rst = r; req = q; add = ad; wen = w; rdy = y; wdata = $urandom; be = 4'($urandom);
    @(negedge clk);
    s_gnt = gnt; s_cen = rom_cen; s_a = rom_a; s_valid = r_valid; s_rdata = r_rdata; s_err = r_err;
    e_valid = !r && q_m.size() > 0 && q_m[0].born < cyc;
    e_pop = e_valid && y;
    e_gnt = !r && q && (q_m.size() - int'(e_pop)) < 2;
    e_cen = !(e_gnt && w && in_rng(ad));
    e_a = (q && !r) ? idx(ad) : last_a;
    chk("model gnt", 32'(gnt), 32'(e_gnt));
    chk("model cen", 32'(rom_cen), 32'(e_cen));
    chk("model rom_a", 32'(rom_a), 32'(e_a));
    chk("model valid", 32'(r_valid), 32'(e_valid));
    if (e_valid) begin
      chk("model rdata", r_rdata, q_m[0].d);
      chk("model err", 32'(r_err), 32'(q_m[0].e));
    end else if (r) begin
      chk("reset rdata", r_rdata, 32'h0);
      chk("reset err", 32'(r_err), 32'h0);
    end
    @(posedge clk);
    if (r) begin
      q_m.delete();
      last_a = '0;
    end else begin
      if (e_pop) void'(q_m.pop_front());
      if (e_gnt) begin
        n.d = !w ? 32'h0 : in_rng(ad) ? rom_word(idx(ad)) : OD;
        n.e = !w ? 1'b1 : in_rng(ad) ? 1'b0 : OE;
        n.born = cyc;
        q_m.push_back(n);
      end
      if (q) last_a = idx(ad);
    end
    cyc++;
    #1;
  endtask
  initial begin
    tv[0]  = v(0, 1, B + 0,    1, 1, 1, 0, 10'd0,   0, 0, 0);
    tv[1]  = v(0, 1, B + 4,    1, 1, 1, 0, 10'd1,   1, 32'h1C008537, 0);
    tv[2]  = v(0, 1, B + 8,    1, 1, 1, 0, 10'd2,   1, 32'hA4A40101, 0);
    tv[3]  = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   1, 32'hA7A70202, 0);
    tv[4]  = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   0, 0, 0);
    tv[5]  = v(0, 1, B + 12,   1, 0, 1, 0, 10'd3,   0, 0, 0);
    tv[6]  = v(0, 1, B + 0,    1, 0, 1, 0, 10'd0,   1, 32'hA6A60303, 0);
    tv[7]  = v(0, 1, B + 4,    1, 0, 0, 1, 10'd1,   1, 32'hA6A60303, 0);
    tv[8]  = v(0, 1, B + 4,    1, 0, 0, 1, 10'd1,   1, 32'hA6A60303, 0);
    tv[9]  = v(0, 1, B + 4,    1, 1, 1, 0, 10'd1,   1, 32'hA6A60303, 0);
    tv[10] = v(0, 1, B + 8,    1, 1, 1, 0, 10'd2,   1, 32'h1C008537, 0);
    tv[11] = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   1, 32'hA4A40101, 0);
    tv[12] = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   1, 32'hA7A70202, 0);
    tv[13] = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   0, 0, 0);
    tv[14] = v(0, 1, B + 4,    0, 1, 1, 1, 10'd1,   0, 0, 0);
    tv[15] = v(0, 0, B + 4,    1, 1, 0, 1, 10'd1,   1, 32'h0, 1);
    tv[16] = v(0, 1, B + 4096, 1, 1, 1, 1, 10'd0,   0, 0, 0);
    tv[17] = v(0, 1, B + 2,    1, 1, 1, 1, 10'd0,   1, OD, OE);
    tv[18] = v(0, 1, B - 4,    1, 1, 1, 1, 10'h3FF, 1, OD, OE);
    tv[19] = v(0, 0, B - 4,    1, 1, 0, 1, 10'h3FF, 1, OD, OE);
    tv[20] = v(0, 0, B - 4,    1, 1, 0, 1, 10'h3FF, 0, 0, 0);
    tv[21] = v(0, 1, B + 0,    1, 0, 1, 0, 10'd0,   0, 0, 0);
    tv[22] = v(0, 1, B + 4,    1, 0, 1, 0, 10'd1,   1, 32'h1C008537, 0);
    tv[23] = v(0, 0, B + 4,    1, 0, 0, 1, 10'd1,   1, 32'h1C008537, 0);
    tv[24] = v(1, 0, B + 4,    1, 0, 0, 1, 10'd1,   0, 0, 0);
    tv[25] = v(0, 1, B + 8,    1, 1, 1, 0, 10'd2,   0, 0, 0);
    tv[26] = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   1, 32'hA7A70202, 0);
    tv[27] = v(0, 0, B + 8,    1, 1, 0, 1, 10'd2,   0, 0, 0);
    rst = 1; req = 0; add = '0; wen = 1; rdy = 0; be = '0; wdata = '0;
    @(posedge clk);
    #1;
    step(1, 0, 32'h0, 1, 0);
    for (int i = 0; i < 28; i++) begin
      step(tv[i].rst, tv[i].req, tv[i].add, tv[i].wen, tv[i].rdy);
      chk($sformatf("vec%0d gnt", i), 32'(s_gnt), 32'(tv[i].gnt));
      chk($sformatf("vec%0d cen", i), 32'(s_cen), 32'(tv[i].cen));
      chk($sformatf("vec%0d rom_a", i), 32'(s_a), 32'(tv[i].a));
      chk($sformatf("vec%0d valid", i), 32'(s_valid), 32'(tv[i].valid));
      if (tv[i].valid || tv[i].rst) begin
        chk($sformatf("vec%0d rdata", i), s_rdata, tv[i].rdata);
        chk($sformatf("vec%0d err", i), 32'(s_err), 32'(tv[i].err));
      end
    end
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ad;
      int sel;
      sel = $urandom_range(0, 7);
      ad = (sel < 4) ? B + 4 * $urandom_range(0, 1023) :
           (sel == 4) ? B + 4092 : (sel == 5) ? B + 4096 :
           (sel == 6) ? B + $urandom_range(0, 4095) : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, ad, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
